// File: rtl/turbosound_bus_seq.sv
// Dual-AY (TurboSound) bus sequencer: CPU port accesses plus an optional register-write stream.
// The stream path exists only when TURBOSOUND_STREAM_EN is defined.
module turbosound_bus_seq #(
   parameter int RESTORE_ADDR = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_req,
   input  logic       cpu_wr,
   input  logic       cpu_port,
   input  logic [7:0] cpu_din,
   output logic       cpu_ack,
   output logic [7:0] cpu_dout,
   input  logic       stream_valid,
   output logic       stream_ready,
   input  logic       stream_chip,
   input  logic [3:0] stream_reg,
   input  logic [7:0] stream_data,
   output logic [1:0] ay_a8,
   output logic       ay_bdir,
   output logic       ay_bc2,
   output logic       ay_bc1,
   output logic [7:0] ay_din,
   input  logic [7:0] ay_dout0,
   input  logic [7:0] ay_dout1,
   output logic       active_chip
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_ADDR, S_WRITE, S_READ
`ifdef TURBOSOUND_STREAM_EN
      , S_RESTORE
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       active_chip_q, active_chip_d;
   logic [7:0] shadow_q [2];
   logic [7:0] shadow_d [2];
   logic [7:0] dout_q, dout_d;
   logic       ack_q, ack_d;
   logic [1:0] a8_q, a8_d;
   logic [7:0] din_q, din_d;
`ifdef TURBOSOUND_STREAM_EN
   logic       strm_q, strm_d;
   logic       strm_chip_q, strm_chip_d;
   logic [7:0] strm_data_q, strm_data_d;
`endif

   function automatic logic [1:0] chip_sel(input logic chip);
      return chip ? 2'b10 : 2'b01;
   endfunction

   always_comb begin
      state_d       = state_q;
      active_chip_d = active_chip_q;
      shadow_d      = shadow_q;
      dout_d        = dout_q;
      ack_d         = 1'b0;
      a8_d          = a8_q;
      din_d         = din_q;
`ifdef TURBOSOUND_STREAM_EN
      strm_d        = strm_q;
      strm_chip_d   = strm_chip_q;
      strm_data_d   = strm_data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               ack_d = 1'b1;
               if (cpu_port && cpu_wr && cpu_din[7:1] == 7'h7F) begin
                  // Chip-select escape: FF selects PSG 0, FE selects PSG 1
                  state_d       = S_SEL;
                  active_chip_d = ~cpu_din[0];
               end else if (cpu_port && cpu_wr) begin
                  state_d                 = S_ADDR;
                  din_d                   = cpu_din;
                  a8_d                    = chip_sel(active_chip_q);
                  shadow_d[active_chip_q] = cpu_din;
               end else if (cpu_port) begin
                  state_d = S_READ;
                  a8_d    = chip_sel(active_chip_q);
               end else if (cpu_wr) begin
                  state_d = S_WRITE;
                  din_d   = cpu_din;
                  a8_d    = chip_sel(active_chip_q);
               end else begin
                  state_d = S_SEL;
                  dout_d  = 8'hFF;
               end
`ifdef TURBOSOUND_STREAM_EN
            end else if (stream_valid) begin
               state_d     = S_ADDR;
               strm_d      = 1'b1;
               strm_chip_d = stream_chip;
               strm_data_d = stream_data;
               din_d       = {4'h0, stream_reg};
               a8_d        = chip_sel(stream_chip);
`endif
            end
         end
         S_ADDR: begin
`ifdef TURBOSOUND_STREAM_EN
            if (strm_q) begin
               state_d = S_WRITE;
               din_d   = strm_data_q;
            end else begin
               state_d = S_IDLE;
               a8_d    = 2'b00;
            end
`else
            state_d = S_IDLE;
            a8_d    = 2'b00;
`endif
         end
         S_WRITE: begin
`ifdef TURBOSOUND_STREAM_EN
            if (strm_q && RESTORE_ADDR != 0) begin
               // Put back the register address the CPU believes is latched
               state_d = S_RESTORE;
               din_d   = shadow_q[strm_chip_q];
            end else begin
               state_d = S_IDLE;
               a8_d    = 2'b00;
               strm_d  = 1'b0;
            end
`else
            state_d = S_IDLE;
            a8_d    = 2'b00;
`endif
         end
         S_READ: begin
            state_d = S_IDLE;
            a8_d    = 2'b00;
            dout_d  = active_chip_q ? ay_dout1 : ay_dout0;
         end
`ifdef TURBOSOUND_STREAM_EN
         S_RESTORE: begin
            state_d = S_IDLE;
            a8_d    = 2'b00;
            strm_d  = 1'b0;
         end
`endif
         default: begin
            state_d = S_IDLE;
            a8_d    = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         active_chip_q <= 1'b0;
         shadow_q[0]   <= 8'h00;
         shadow_q[1]   <= 8'h00;
         dout_q        <= 8'hFF;
         ack_q         <= 1'b0;
         a8_q          <= 2'b00;
         din_q         <= 8'h00;
`ifdef TURBOSOUND_STREAM_EN
         strm_q        <= 1'b0;
         strm_chip_q   <= 1'b0;
         strm_data_q   <= 8'h00;
`endif
      end else begin
         state_q       <= state_d;
         active_chip_q <= active_chip_d;
         shadow_q      <= shadow_d;
         dout_q        <= dout_d;
         ack_q         <= ack_d;
         a8_q          <= a8_d;
         din_q         <= din_d;
`ifdef TURBOSOUND_STREAM_EN
         strm_q        <= strm_d;
         strm_chip_q   <= strm_chip_d;
         strm_data_q   <= strm_data_d;
`endif
      end
   end

   always_comb begin
      {ay_bdir, ay_bc2, ay_bc1} = 3'b000;
      case (state_q)
         S_ADDR:    {ay_bdir, ay_bc2, ay_bc1} = 3'b111;
         S_WRITE:   {ay_bdir, ay_bc2, ay_bc1} = 3'b110;
         S_READ:    {ay_bdir, ay_bc2, ay_bc1} = 3'b011;
`ifdef TURBOSOUND_STREAM_EN
         S_RESTORE: {ay_bdir, ay_bc2, ay_bc1} = 3'b111;
`endif
         default:   {ay_bdir, ay_bc2, ay_bc1} = 3'b000;
      endcase
   end

`ifdef TURBOSOUND_STREAM_EN
   assign stream_ready = rst_n && (state_q == S_IDLE) && !cpu_req;
`else
   logic unused_stream;
   assign unused_stream = ^{stream_valid, stream_chip, stream_reg, stream_data, (RESTORE_ADDR != 0)};
   assign stream_ready  = 1'b0;
`endif

   assign cpu_ack     = ack_q;
   assign cpu_dout    = dout_q;
   assign ay_a8       = a8_q;
   assign ay_din      = din_q;
   assign active_chip = active_chip_q;

endmodule
